// File: rtl/coinc_trigger_axi_pkg.sv
// Shared definitions for the coincTrigger AXI4-Lite register file.
package coinc_trigger_axi_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned NUM_CTRL = 4;
    localparam int unsigned ADDR_W   = 5;

    // Word-aligned byte offsets of the non-RW locations
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 5'h10;
    localparam logic [ADDR_W-1:0] ADDR_COUNT    = 5'h14;
    localparam logic [ADDR_W-1:0] ADDR_CLEAR    = 5'h18;
    localparam logic [ADDR_W-1:0] ADDR_UNMAPPED = 5'h1C;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Clear the two ignored byte-offset bits of an AXI address
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/coinc_event_counter.sv
// Saturating coincidence-event counter; clear has priority over increment.
module coinc_event_counter
    import coinc_trigger_axi_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [DATA_W-1:0] count_o
);

    logic [DATA_W-1:0] count_q;
    logic [DATA_W-1:0] count_d;

    // Next count: clear wins, otherwise increment unless already at all-ones
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {DATA_W{1'b1}})) begin
            count_d = count_q + DATA_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/coinc_trigger_axil_regs.sv
// AXI4-Lite slave register file for the coincTrigger IP: 4 RW control words,
// live status, saturating event counter and its clear strobe.
module coinc_trigger_axil_regs
    import coinc_trigger_axi_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   status_in,
    input  logic                            coinc_event,
    output logic                            count_clear
);

    // Write channel state
    wr_state_t                         wr_state_q, wr_state_d;
    logic                              awready_q, awready_d;
    logic                              wready_q, wready_d;
    logic                              aw_got_q, aw_got_d;
    logic                              w_got_q, w_got_d;
    logic [ADDR_W-1:0]                 waddr_q, waddr_d;
    logic [DATA_W-1:0]                 wdata_q, wdata_d;
    logic [STRB_W-1:0]                 wstrb_q, wstrb_d;
    logic                              bvalid_q, bvalid_d;
    logic [1:0]                        bresp_q, bresp_d;
    logic [NUM_CTRL-1:0][DATA_W-1:0]   regs_q, regs_d;
    logic                              count_clear_q;
    logic                              clr_c;
    logic                              aw_hs_c;
    logic                              w_hs_c;

    // Read channel state
    rd_state_t                         rd_state_q, rd_state_d;
    logic                              arready_q, arready_d;
    logic                              rvalid_q, rvalid_d;
    logic [DATA_W-1:0]                 rdata_q, rdata_d;
    logic [1:0]                        rresp_q, rresp_d;
    logic [ADDR_W-1:0]                 raddr_c;
    logic [DATA_W-1:0]                 rd_word_c;
    logic                              ar_hs_c;

    logic [DATA_W-1:0]                 count_c;
    logic                              unused_c;

    assign unused_c = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign aw_hs_c = s00_axi_awvalid & awready_q;
    assign w_hs_c  = s00_axi_wvalid  & wready_q;
    assign ar_hs_c = s00_axi_arvalid & arready_q;
    assign raddr_c = word_align(s00_axi_araddr);

    // Write FSM: collect AW and W in any order, commit for one cycle, then respond
    always_comb begin
        wr_state_d = wr_state_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        clr_c      = 1'b0;

        unique case (wr_state_q)
            W_IDLE: begin
                if (aw_hs_c) begin
                    aw_got_d = 1'b1;
                    waddr_d  = word_align(s00_axi_awaddr);
                end
                if (w_hs_c) begin
                    w_got_d = 1'b1;
                    wdata_d = s00_axi_wdata;
                    wstrb_d = s00_axi_wstrb;
                end
                if (aw_got_d && w_got_d) begin
                    wr_state_d = W_COMMIT;
                end
            end
            W_COMMIT: begin
                aw_got_d   = 1'b0;
                w_got_d    = 1'b0;
                bvalid_d   = 1'b1;
                bresp_d    = AXI_RESP_OKAY;
                wr_state_d = W_RESP;
                if (waddr_q < ADDR_STATUS) begin
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (wstrb_q[b]) begin
                            regs_d[waddr_q[3:2]][8*b +: 8] = wdata_q[8*b +: 8];
                        end
                    end
                end else if (waddr_q == ADDR_CLEAR) begin
                    clr_c = wdata_q[0] & wstrb_q[0];
                end else if (waddr_q == ADDR_UNMAPPED) begin
                    bresp_d = AXI_RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (s00_axi_bready) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
            end
        endcase

        awready_d = (wr_state_d == W_IDLE) && !aw_got_d;
        wready_d  = (wr_state_d == W_IDLE) && !w_got_d;
    end

    // Write-side registers
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            wr_state_q    <= W_IDLE;
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            aw_got_q      <= 1'b0;
            w_got_q       <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            bvalid_q      <= 1'b0;
            bresp_q       <= AXI_RESP_OKAY;
            regs_q        <= '0;
            count_clear_q <= 1'b0;
        end else begin
            wr_state_q    <= wr_state_d;
            awready_q     <= awready_d;
            wready_q      <= wready_d;
            aw_got_q      <= aw_got_d;
            w_got_q       <= w_got_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            regs_q        <= regs_d;
            count_clear_q <= clr_c;
        end
    end

    // Read data mux; sees pre-update register and counter values
    always_comb begin
        rd_word_c = '0;
        if (raddr_c < ADDR_STATUS) begin
            rd_word_c = regs_q[raddr_c[3:2]];
        end else if (raddr_c == ADDR_STATUS) begin
            rd_word_c = status_in;
        end else if (raddr_c == ADDR_COUNT) begin
            rd_word_c = count_c;
        end
    end

    // Read FSM: capture on AR handshake, hold until R handshake
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        unique case (rd_state_q)
            R_IDLE: begin
                if (ar_hs_c) begin
                    rd_state_d = R_DATA;
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_word_c;
                    rresp_d    = (raddr_c == ADDR_UNMAPPED) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                end
            end
            R_DATA: begin
                if (s00_axi_rready) begin
                    rd_state_d = R_IDLE;
                    rvalid_d   = 1'b0;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase

        arready_d = (rd_state_d == R_IDLE);
    end

    // Read-side registers
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= AXI_RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    coinc_event_counter u_counter (
        .clk_i   (s00_axi_aclk),
        .rst_i   (s00_axi_areset),
        .inc_i   (coinc_event),
        .clr_i   (clr_c),
        .count_o (count_c)
    );

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;
    assign ctrl_regs       = regs_q;
    assign count_clear     = count_clear_q;

endmodule

// File: tb/tb_coinc_trigger_axil_regs.sv
// Self-checking bench for coinc_trigger_axil_regs with a behavioural register/counter model.
module tb_coinc_trigger_axil_regs;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [4:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] ctrl_regs;
    logic [31:0]  status_in;
    logic         coinc_event;
    logic         count_clear;

    int assertions = 0;
    int failures   = 0;

    logic [31:0] m_regs [4];
    logic [31:0] m_count;

    always #5 clk = ~clk;

    coinc_trigger_axil_regs dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (rst),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .ctrl_regs       (ctrl_regs),
        .status_in       (status_in),
        .coinc_event     (coinc_event),
        .count_clear     (count_clear)
    );

    // ---------------- reference model ----------------
    function automatic logic [127:0] m_ctrl();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a[4] == 1'b0) return m_regs[a[3:2]];
        if (a[3:2] == 2'd0) return status_in;
        if (a[3:2] == 2'd1) return m_count;
        return 32'h0;
    endfunction

    function automatic logic [1:0] m_resp(input logic [4:0] a);
        return (a[4:2] == 3'd7) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{s[b]}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    task automatic m_inc();
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
        m_count = 32'h0;
    endtask

    task automatic m_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input bit ev);
        if (a[4] == 1'b0) m_regs[a[3:2]] = merge(m_regs[a[3:2]], d, s);
        if (a[4:2] == 3'd6 && d[0] && s[0]) m_count = 32'h0;
        else if (ev) m_inc();
    endtask

    // ---------------- bus helpers (enter and leave on a falling edge) ----------------
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input bit ev);
        logic [1:0] resp;
        bit exp_clr;
        int n;
        exp_clr = (a[4:2] == 3'd6) && d[0] && s[0];
        n = 0;
        while (!(awready === 1'b1 && wready === 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        assertions++;
        if (n >= 20) begin
            failures++;
            $display("FAIL wr_ready_timeout awready=%b wready=%b required 1/1", awready, wready);
        end
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        assertions++;
        if (bvalid !== 1'b0 || awready !== 1'b0 || wready !== 1'b0) begin
            failures++;
            $display("FAIL wr_commit_phase bvalid=%b awready=%b wready=%b required 0/0/0", bvalid, awready, wready);
        end
        coinc_event = ev;
        @(negedge clk);
        coinc_event = 1'b0;
        assertions++;
        if (bvalid !== 1'b1) begin
            failures++;
            $display("FAIL wr_bvalid_latency bvalid=%b required 1", bvalid);
        end
        assertions++;
        if (count_clear !== exp_clr) begin
            failures++;
            $display("FAIL wr_count_clear got=%b required %b", count_clear, exp_clr);
        end
        resp = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        assertions++;
        if (bvalid !== 1'b0 || count_clear !== 1'b0 || awready !== 1'b1) begin
            failures++;
            $display("FAIL wr_after_resp bvalid=%b count_clear=%b awready=%b required 0/0/1", bvalid, count_clear, awready);
        end
        m_write(a, d, s, ev);
        assertions++;
        if (resp !== m_resp(a)) begin
            failures++;
            $display("FAIL wr_bresp addr=%h got=%b required %b", a, resp, m_resp(a));
        end
        assertions++;
        if (ctrl_regs !== m_ctrl()) begin
            failures++;
            $display("FAIL wr_ctrl_regs got=%h required %h", ctrl_regs, m_ctrl());
        end
    endtask

    task automatic rd(input logic [4:0] a);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        int n;
        n = 0;
        while (arready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        assertions++;
        if (n >= 20) begin
            failures++;
            $display("FAIL rd_ready_timeout arready=%b required 1", arready);
        end
        exp_d = m_read(a);
        exp_r = m_resp(a);
        araddr = a; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        assertions++;
        if (rvalid !== 1'b1 || arready !== 1'b0) begin
            failures++;
            $display("FAIL rd_rvalid rvalid=%b arready=%b required 1/0", rvalid, arready);
        end
        assertions++;
        if (rdata !== exp_d || rresp !== exp_r) begin
            failures++;
            $display("FAIL rd_data addr=%h got=%h/%b required %h/%b", a, rdata, rresp, exp_d, exp_r);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        assertions++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            failures++;
            $display("FAIL rd_after_resp rvalid=%b arready=%b required 0/1", rvalid, arready);
        end
    endtask

    task automatic pulse_events(input int n);
        for (int i = 0; i < n; i++) begin
            coinc_event = 1'b1;
            @(negedge clk);
            coinc_event = 1'b0;
            m_inc();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        coinc_event = 1'b1;
        repeat (3) @(negedge clk);
        assertions++;
        if ({awready, wready, arready, bvalid, rvalid, count_clear} !== 6'b0 ||
            bresp !== 2'b0 || rresp !== 2'b0 || rdata !== 32'h0 || ctrl_regs !== 128'h0) begin
            failures++;
            $display("FAIL reset_outputs rdy=%b%b%b bv=%b rv=%b cc=%b rdata=%h ctrl=%h required all 0",
                     awready, wready, arready, bvalid, rvalid, count_clear, rdata, ctrl_regs);
        end
        coinc_event = 1'b0;
        rst = 1'b0;
        m_reset();
        #1;
        assertions++;
        if ({awready, wready, arready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_release_readies got=%b required 000", {awready, wready, arready});
        end
        @(negedge clk);
        assertions++;
        if ({awready, wready, arready} !== 3'b111) begin
            failures++;
            $display("FAIL readies_after_reset got=%b required 111", {awready, wready, arready});
        end
        rd(5'h14);
    endtask

    task automatic test_rw_basic();
        for (int i = 0; i < 4; i++) wr(5'(4 * i), 32'(i + 1), 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) rd(5'(4 * i));
        assertions++;
        if (ctrl_regs !== 128'h00000004_00000003_00000002_00000001) begin
            failures++;
            $display("FAIL basic_ctrl_regs got=%h required 00000004000000030000000200000001", ctrl_regs);
        end
    endtask

    task automatic split_write(input logic [4:0] a, input logic [31:0] d, input bit aw_first);
        int n;
        int extra;
        if (aw_first) begin awaddr = a; awvalid = 1'b1; end
        else begin wdata = d; wstrb = 4'hF; wvalid = 1'b1; end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        assertions++;
        if ((aw_first && (awready !== 1'b0 || wready !== 1'b1)) ||
            (!aw_first && (wready !== 1'b0 || awready !== 1'b1))) begin
            failures++;
            $display("FAIL split_ready_drop awready=%b wready=%b aw_first=%0d", awready, wready, aw_first);
        end
        repeat (2) begin
            @(negedge clk);
            assertions++;
            if (bvalid !== 1'b0) begin
                failures++;
                $display("FAIL split_early_bvalid bvalid=%b required 0", bvalid);
            end
        end
        if (aw_first) begin wdata = d; wstrb = 4'hF; wvalid = 1'b1; end
        else begin awaddr = a; awvalid = 1'b1; end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (bvalid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        assertions++;
        if (n != 1) begin
            failures++;
            $display("FAIL split_bvalid_wait cycles=%0d required 1", n);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (bvalid === 1'b1) extra++;
        end
        assertions++;
        if (extra != 0) begin
            failures++;
            $display("FAIL split_extra_bvalid got=%0d required 0", extra);
        end
        m_write(a, d, 4'hF, 1'b0);
        assertions++;
        if (ctrl_regs !== m_ctrl()) begin
            failures++;
            $display("FAIL split_ctrl_regs got=%h required %h", ctrl_regs, m_ctrl());
        end
    endtask

    task automatic test_out_of_order();
        split_write(5'h04, 32'h3C3C_3C3C, 1'b0);
        split_write(5'h04, 32'hA5A5_A5A5, 1'b1);
        assertions++;
        if (ctrl_regs[63:32] !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL ooo_reg1 got=%h required a5a5a5a5", ctrl_regs[63:32]);
        end
        rd(5'h04);
    endtask

    task automatic test_strobe();
        wr(5'h00, 32'hFFFF_FFFF, 4'hF, 1'b0);
        wr(5'h00, 32'h0000_0000, 4'b0101, 1'b0);
        assertions++;
        if (ctrl_regs[31:0] !== 32'hFF00_FF00) begin
            failures++;
            $display("FAIL strobe_reg0 got=%h required ff00ff00", ctrl_regs[31:0]);
        end
        rd(5'h00);
    endtask

    task automatic test_counter();
        logic [31:0] exp;
        pulse_events(10);
        assertions++;
        if (m_read(5'h14) !== 32'd10) begin
            failures++;
            $display("FAIL counter_model got=%0d required 10", m_read(5'h14));
        end
        rd(5'h14);
        // read captured together with an event sees the pre-increment value
        exp = m_count;
        araddr = 5'h14; arvalid = 1'b1; coinc_event = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; coinc_event = 1'b0;
        m_inc();
        assertions++;
        if (rvalid !== 1'b1 || rdata !== exp) begin
            failures++;
            $display("FAIL count_read_vs_event rvalid=%b rdata=%0d required 1/%0d", rvalid, rdata, exp);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        rd(5'h14);
        // clear with a coincident event: clear wins
        wr(5'h18, 32'h1, 4'h1, 1'b1);
        rd(5'h14);
        rd(5'h18);
    endtask

    task automatic test_errors();
        wr(5'h1C, 32'h1234_5678, 4'hF, 1'b0);
        rd(5'h1C);
        status_in = 32'hC0DE_0001;
        wr(5'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
        rd(5'h10);
        status_in = 32'h5555_AAAA;
        rd(5'h10);
        wr(5'h14, 32'hFFFF_FFFF, 4'hF, 1'b0);
        rd(5'h14);
    endtask

    task automatic test_collision();
        logic [31:0] old_v;
        logic [31:0] new_v;
        old_v = m_regs[2];
        new_v = ~old_v ^ 32'h0F0F_0001;
        awaddr = 5'h08; wdata = new_v; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 5'h08; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        assertions++;
        if (rvalid !== 1'b1 || rdata !== old_v) begin
            failures++;
            $display("FAIL collision_read_old rvalid=%b rdata=%h required 1/%h", rvalid, rdata, old_v);
        end
        assertions++;
        if (bvalid !== 1'b1 || ctrl_regs[95:64] !== new_v) begin
            failures++;
            $display("FAIL collision_write bvalid=%b reg2=%h required 1/%h", bvalid, ctrl_regs[95:64], new_v);
        end
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        m_regs[2] = new_v;
        rd(5'h08);
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        awaddr = 5'h1C; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awaddr = 5'h00; wdata = 32'hBAD0_BAD0;
        @(negedge clk);
        repeat (5) begin
            assertions++;
            if (bvalid !== 1'b1 || bresp !== 2'b10 || awready !== 1'b0 || wready !== 1'b0) begin
                failures++;
                $display("FAIL bp_write_hold bvalid=%b bresp=%b awready=%b wready=%b required 1/10/0/0",
                         bvalid, bresp, awready, wready);
            end
            @(negedge clk);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        assertions++;
        if (bvalid !== 1'b0 || ctrl_regs !== m_ctrl()) begin
            failures++;
            $display("FAIL bp_write_release bvalid=%b ctrl=%h required 0/%h", bvalid, ctrl_regs, m_ctrl());
        end
        exp = m_read(5'h04);
        araddr = 5'h04; arvalid = 1'b1;
        @(negedge clk);
        araddr = 5'h00;
        repeat (5) begin
            assertions++;
            if (rvalid !== 1'b1 || rdata !== exp || rresp !== 2'b00 || arready !== 1'b0) begin
                failures++;
                $display("FAIL bp_read_hold rvalid=%b rdata=%h rresp=%b arready=%b required 1/%h/00/0",
                         rvalid, rdata, rresp, arready, exp);
            end
            @(negedge clk);
        end
        arvalid = 1'b0;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        assertions++;
        if (rvalid !== 1'b0) begin
            failures++;
            $display("FAIL bp_read_release rvalid=%b required 0", rvalid);
        end
    endtask

    task automatic test_random();
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        for (int i = 0; i < 60; i++) begin
            status_in = $urandom;
            a = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0, 1: begin
                    d = $urandom;
                    s = 4'($urandom_range(0, 15));
                    wr(a, d, s, 1'($urandom_range(0, 1)));
                end
                2: rd(a);
                default: pulse_events(int'($urandom_range(1, 3)));
            endcase
        end
        for (int i = 0; i < 8; i++) rd(5'(4 * i));
    endtask

    task automatic test_reset_mid();
        awaddr = 5'h0C; wdata = 32'h7777_1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        assertions++;
        if (bvalid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_in_resp bvalid=%b required 1", bvalid);
        end
        #2 rst = 1'b1;
        #1;
        assertions++;
        if (bvalid !== 1'b0 || ctrl_regs !== 128'h0 || awready !== 1'b0 || count_clear !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async bvalid=%b ctrl=%h awready=%b required 0/0/0", bvalid, ctrl_regs, awready);
        end
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        assertions++;
        if ({awready, wready, arready, bvalid} !== 4'b1110) begin
            failures++;
            $display("FAIL rstmid_recover got=%b required 1110", {awready, wready, arready, bvalid});
        end
        rd(5'h0C);
        rd(5'h14);
        wr(5'h0C, 32'h0000_00AB, 4'h1, 1'b0);
        rd(5'h0C);
    endtask

    initial begin
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        status_in = 32'h0BAD_F00D; coinc_event = 1'b0; rst = 1'b1;
        m_reset();
        test_reset();
        test_rw_basic();
        test_out_of_order();
        test_strobe();
        test_counter();
        test_errors();
        test_collision();
        test_backpressure();
        test_random();
        pulse_events(4);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog_timeout simulation time exceeded");
        $fatal(1, "watchdog");
    end

endmodule
